// File: rtl/grey_fb_writer.sv
// grey_fb_writer: packs 4 grey pixels per 32-bit word and writes them to a linear frame buffer.
// Define DOUBLE_BUFFER_EN to alternate frames between BASE0 and BASE1.
module grey_fb_writer #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 18,
   parameter int BASE0  = 0,
   parameter int BASE1  = 76800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [7:0]        pix_grey,
   input  logic              pix_sof,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              frame_done,
   output logic              sof_err,
   output logic              rd_buf
);
   localparam int WORDS = H_RES * V_RES / 4;
   typedef enum logic [1:0] {IDLE, PACK, WRITE} state_t;
   state_t state, state_nx;
   logic [1:0] byte_idx;
   logic [ADDR_W-1:0] word_cnt, base;
   logic [23:0] pend;
   logic wr_buf, take, start, last, done;
   assign pix_ready = state != WRITE;
   assign mem_req = state == WRITE;
   assign take = pix_valid & pix_ready;
   assign start = take & pix_sof;
   assign last = word_cnt == ADDR_W'(WORDS - 1);
   assign done = mem_req & mem_ack & last;
   assign base = wr_buf ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (start) state_nx = PACK;
      else if (state == PACK && take && byte_idx == 2'd3) state_nx = WRITE;
      else if (mem_req && mem_ack) state_nx = last ? IDLE : PACK;
   end
   // sof always restarts the frame; it is an error only when a frame was already underway
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         byte_idx   <= '0;
         word_cnt   <= '0;
         pend       <= '0;
         mem_addr   <= ADDR_W'(BASE0);
         mem_wdata  <= '0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         frame_done <= done;
         sof_err <= start && state == PACK;
         if (start) begin
            pend[7:0] <= pix_grey;
            byte_idx <= 2'd1;
            word_cnt <= '0;
         end else if (take && state == PACK) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
               mem_wdata <= {pix_grey, pend};
               mem_addr <= base + word_cnt;
            end else pend[{byte_idx, 3'b000} +: 8] <= pix_grey;
         end else if (mem_req && mem_ack) word_cnt <= last ? '0 : word_cnt + ADDR_W'(1);
      end
`ifdef DOUBLE_BUFFER_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_buf <= 1'b0;
         rd_buf <= 1'b0;
      end else if (done) begin
         rd_buf <= wr_buf;
         wr_buf <= !wr_buf;
      end
`else
   assign wr_buf = 1'b0;
   assign rd_buf = 1'b0;
`endif
endmodule
